cdb_broadcast_arbiter: RTL

Parametrised common-data-bus arbiter. It sits between NUM_FU functional-unit result ports and the ROB/reservation-station broadcast bus, and generalises the fixed 7-FU dispatch broadcast queue. Each cycle it grants at most one pending FU result, using round-robin or fixed priority. Granted results are stored in a parametrised tag+data FIFO and broadcast one per cycle unless halted. It also provides an explicit per-FU acknowledge handshake, a flush input and an occupancy count.

---
 rtl/cdb_broadcast_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus arbiter: grants one FU result per cycle into a tag+data FIFO and broadcasts one per cycle.
// Optional BCAST_BYPASS_EN: a grant into an empty, un-halted queue goes straight to the output register.
module cdb_broadcast_arbiter #(
  parameter int NUM_FU        = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 7,
  parameter int QUEUE_DEPTH   = 16,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
  input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
  output logic [NUM_FU-1:0]              fu_ack,
  input  logic                           halt,
  input  logic                           flush,
  output logic                           bcast_valid,
  output logic [TAG_WIDTH-1:0]           bcast_tag,
  output logic [DATA_WIDTH-1:0]          bcast_data,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           queue_full,
  output logic                           queue_empty
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int PW = $clog2(NUM_FU);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          lane [NUM_FU];
  entry_t          mem  [QUEUE_DEPTH];
  entry_t          sel;
  logic [PW-1:0]   idx;
  logic            found, grant, push, pop, bypass;
  logic [AW-1:0]   wr_ptr, rd_ptr;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    assign lane[g] = {fu_tag[g*TAG_WIDTH +: TAG_WIDTH], fu_data[g*DATA_WIDTH +: DATA_WIDTH]};
  end

  if (PRIORITY_MODE == 1) begin : g_fixed
    // Ascending scan: the last hit is the highest valid index.
    always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_FU; i++)
        if (fu_valid[i]) begin
          found = 1'b1;
          idx   = PW'(i);
        end
    end
  end else begin : g_rr
    logic [PW-1:0]     ptr, off;
    logic [PW:0]       sum;
    logic [NUM_FU-1:0] rot;

    // Rotate so bit 0 is the FU at ptr; the lowest set bit is the winner.
    assign rot = NUM_FU'({fu_valid, fu_valid} >> ptr);

    always_comb begin
      found = 1'b0;
      off   = '0;
      for (int k = NUM_FU-1; k >= 0; k--)
        if (rot[k]) begin
          found = 1'b1;
          off   = PW'(k);
        end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (PW+1)'(NUM_FU)) sum = sum - (PW+1)'(NUM_FU);
      idx = sum[PW-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst)        ptr <= '0;
      else if (grant) ptr <= (idx == PW'(NUM_FU-1)) ? '0 : idx + 1'b1;
    end
  end

  assign grant  = found & ~queue_full & ~flush & ~rst;
  assign fu_ack = grant ? (NUM_FU'(1) << idx) : '0;
  assign sel    = lane[idx];
  assign pop    = ~queue_empty & ~halt;
`ifdef BCAST_BYPASS_EN
  assign bypass = grant & queue_empty & ~halt;
`else
  assign bypass = 1'b0;
`endif
  assign push   = grant & ~bypass;

  assign queue_full  = (queue_count == (AW+1)'(QUEUE_DEPTH));
  assign queue_empty = (queue_count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      bcast_valid <= 1'b0;
      bcast_tag   <= '0;
      bcast_data  <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      bcast_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
      if (pop) begin
        bcast_valid <= 1'b1;
        bcast_tag   <= mem[rd_ptr].tag;
        bcast_data  <= mem[rd_ptr].data;
      end else if (bypass) begin
        bcast_valid <= 1'b1;
        bcast_tag   <= sel.tag;
        bcast_data  <= sel.data;
      end else begin
        bcast_valid <= 1'b0;
      end
    end
  end
endmodule
